ex_alu_stage: RTL and testbench

- Execute stage directly downstream of the sign/shift extender.
- Combines Rn with the extender's 32-bit shifter operand and shifter carry-out, and performs the ARM data-processing opcode.
- Registers the result with a valid/ready handshake toward MEM/WB.
- Owns the architectural N/Z/C/V flag register.

---
 rtl/ex_alu_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_alu_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// ARM data-processing execute stage: ALU, N/Z/C/V flag register and a one-deep
// result register with valid/ready handshake. Define ALU_MUL_EN to add the iterative MUL.
module ex_alu_stage #(
  parameter int         DATA_W    = 32,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic              s_bit,
  input  logic              mul_en,
  input  logic [DATA_W-1:0] rn_val,
  input  logic [DATA_W-1:0] shift_result,
  input  logic              shift_c,
  input  logic [3:0]        rd_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        out_rd,
  output logic              out_wr_en,
  output logic [3:0]        flags
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MUL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              c;
    logic              v;
  } alu_out_t;

  // Subtracts run through the same adder as x + ~y + cin so C is NOT-borrow.
  function automatic alu_out_t alu_exec(input logic [3:0] op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic cin, input logic sc,
                                        input logic vin);
    alu_out_t          o;
    logic [DATA_W-1:0] x, y;
    logic              ci;
    logic [DATA_W:0]   sum;
    x = a;
    y = b;
    ci = 1'b0;
    case (op)
      4'h2, 4'hA: begin x = a; y = ~b; ci = 1'b1; end
      4'h3:       begin x = b; y = ~a; ci = 1'b1; end
      4'h5:       begin x = a; y = b;  ci = cin;  end
      4'h6:       begin x = a; y = ~b; ci = cin;  end
      4'h7:       begin x = b; y = ~a; ci = cin;  end
      default:    begin x = a; y = b;  ci = 1'b0; end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, ci};
    o.res = sum[DATA_W-1:0];
    o.c   = sum[DATA_W];
    o.v   = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
    case (op)
      4'h0, 4'h8: o.res = a & b;
      4'h1, 4'h9: o.res = a ^ b;
      4'hC:       o.res = a | b;
      4'hD:       o.res = b;
      4'hE:       o.res = a & ~b;
      4'hF:       o.res = ~b;
      default:    o.res = sum[DATA_W-1:0];
    endcase
    if (op == 4'h0 || op == 4'h1 || op == 4'h8 || op == 4'h9 || op[3:2] == 2'b11) begin
      o.c = sc;
      o.v = vin;
    end
    return o;
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        rd_q, rd_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        flags_q, flags_d;
  logic              accept;
  logic              is_test;
  alu_out_t          alu;

`ifdef ALU_MUL_EN
  logic [DATA_W-1:0] mcnd_q, mcnd_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ms_q, ms_d;
  assign in_ready = (state_q != S_MUL) && (!out_valid || out_ready);
`else
  logic mul_en_unused;
  assign mul_en_unused = mul_en;
  assign in_ready = !out_valid || out_ready;
`endif

  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign out_rd    = rd_q;
  assign out_wr_en = wr_en_q;
  assign flags     = flags_q;
  assign accept    = in_valid && in_ready;
  assign is_test   = (opcode[3:2] == 2'b10);
  assign alu       = alu_exec(opcode, rn_val, shift_result, flags_q[1], shift_c, flags_q[0]);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rd_d     = rd_q;
    wr_en_d  = wr_en_q;
    flags_d  = flags_q;
`ifdef ALU_MUL_EN
    mcnd_d = mcnd_q;
    mplr_d = mplr_q;
    cnt_d  = cnt_q;
    ms_d   = ms_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
`ifdef ALU_MUL_EN
    end else if (state_q == S_MUL) begin
      // One shift-add step per cycle; result_q doubles as the accumulator.
      result_d = result_q + (mplr_q[0] ? mcnd_q : '0);
      mcnd_d   = mcnd_q << 1;
      mplr_d   = mplr_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = S_HOLD;
        if (ms_q) flags_d[3:2] = {result_d[DATA_W-1], (result_d == '0)};
      end
    end else if (accept && mul_en) begin
      state_d  = S_MUL;
      result_d = '0;
      mcnd_d   = rn_val;
      mplr_d   = shift_result;
      cnt_d    = '0;
      ms_d     = s_bit;
      rd_d     = rd_addr;
      wr_en_d  = 1'b1;
`endif
    end else if (accept) begin
      state_d  = S_HOLD;
      result_d = alu.res;
      rd_d     = rd_addr;
      wr_en_d  = !is_test;
      if (s_bit || is_test)
        flags_d = {alu.res[DATA_W-1], (alu.res == '0), alu.c, alu.v};
    end else if (out_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rd_q     <= '0;
      wr_en_q  <= 1'b0;
      flags_q  <= FLAGS_RST;
`ifdef ALU_MUL_EN
      mcnd_q <= '0;
      mplr_q <= '0;
      cnt_q  <= '0;
      ms_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_en_q  <= wr_en_d;
      flags_q  <= flags_d;
`ifdef ALU_MUL_EN
      mcnd_q <= mcnd_d;
      mplr_q <= mplr_d;
      cnt_q  <= cnt_d;
      ms_q   <= ms_d;
`endif
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus randomized
// instructions checked against an arithmetic reference model of the ARM flags.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'h0;
  logic        s_bit = 1'b0;
  logic        mul_en = 1'b0;
  logic [31:0] rn_val = '0;
  logic [31:0] shift_result = '0;
  logic        shift_c = 1'b0;
  logic [3:0]  rd_addr = 4'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;
  logic [3:0] m_flags;

  ex_alu_stage #(.DATA_W(32), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .s_bit(s_bit), .mul_en(mul_en), .rn_val(rn_val),
    .shift_result(shift_result), .shift_c(shift_c), .rd_addr(rd_addr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_rd(out_rd), .out_wr_en(out_wr_en), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: plain wide-integer arithmetic on ARM semantics.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic sc,
                                input logic s, inout logic [3:0] fl,
                                output logic [31:0] res, output logic wr);
    longint ua, ub, sa, sb, full, sf, borrow;
    logic c, v, logical;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    borrow = fl[1] ? 0 : 1;
    logical = 1'b0;
    full = 0; sf = 0; c = 1'b0;
    case (op)
      4'h4, 4'hB: begin full = ua + ub; sf = sa + sb; c = (full > 64'hFFFF_FFFF); end
      4'h5: begin full = ua + ub + (1 - borrow); sf = sa + sb + (1 - borrow); c = (full > 64'hFFFF_FFFF); end
      4'h2, 4'hA: begin full = ua - ub; sf = sa - sb; c = (full >= 0); end
      4'h3: begin full = ub - ua; sf = sb - sa; c = (full >= 0); end
      4'h6: begin full = ua - ub - borrow; sf = sa - sb - borrow; c = (full >= 0); end
      4'h7: begin full = ub - ua - borrow; sf = sb - sa - borrow; c = (full >= 0); end
      default: logical = 1'b1;
    endcase
    v = (sf > 64'sd2147483647) || (sf < -64'sd2147483648);
    res = full[31:0];
    case (op)
      4'h0, 4'h8: res = a & b;
      4'h1, 4'h9: res = a ^ b;
      4'hC: res = a | b;
      4'hD: res = b;
      4'hE: res = a & ~b;
      4'hF: res = ~b;
      default: ;
    endcase
    wr = !(op >= 4'h8 && op <= 4'hB);
    if (s || !wr)
      fl = logical ? {res[31], res == 32'h0, sc, fl[0]} : {res[31], res == 32'h0, c, v};
  endfunction

  task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic sc, input logic [3:0] rd);
    in_valid = 1'b1; opcode = op; s_bit = s; rn_val = a;
    shift_result = b; shift_c = sc; rd_addr = rd; mul_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (out_rd !== 4'h0 || out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_rd_wr: got %h/%b want 0/0", out_rd, out_wr_en); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    tick(); tick();
    reset = 1'b0;
    m_flags = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_overflow();
    logic [31:0] r; logic w;
    drive(4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h3);
    model(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, m_flags, r, w);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result: got v=%b %h want v=1 80000000", out_valid, result); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL add_ovf_flags: got %b want 1001", flags); end
    checks++; if (out_wr_en !== 1'b1 || out_rd !== 4'h3) begin errors++; $display("FAIL add_ovf_wr: got %b/%h want 1/3", out_wr_en, out_rd); end
    tick();
  endtask

  task automatic test_cmp_adc();
    logic [31:0] r; logic w;
    drive(4'hA, 1'b0, 32'd5, 32'd5, 1'b0, 4'h1);
    model(4'hA, 32'd5, 32'd5, 1'b0, 1'b0, m_flags, r, w);
    tick();
    checks++; if (out_wr_en !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL cmp_wr: got wr=%b v=%b want 0/1", out_wr_en, out_valid); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL cmp_flags: got %b want 0110", flags); end
    drive(4'h5, 1'b0, 32'd1, 32'd1, 1'b0, 4'h2);
    model(4'h5, 32'd1, 32'd1, 1'b0, 1'b0, m_flags, r, w);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL adc_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (result !== 32'd3 || out_wr_en !== 1'b1) begin errors++; $display("FAIL adc_carry_in: got %h wr=%b want 3 wr=1", result, out_wr_en); end
    tick();
  endtask

  task automatic test_mov_flags();
    logic [31:0] r; logic w;
    drive(4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h3);
    model(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, m_flags, r, w);
    tick();
    drive(4'hD, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'h4);
    model(4'hD, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1, m_flags, r, w);
    tick();
    in_valid = 1'b0;
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL mov_result: got %h want 0", result); end
    checks++; if (flags !== 4'b0111) begin errors++; $display("FAIL mov_flags: got %b want 0111", flags); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic w;
    out_ready = 1'b0;
    drive(4'h0, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 1'b0, 4'h5);
    model(4'h0, 32'hF0F0_1234, 32'hFF00_FF00, 1'b0, 1'b0, m_flags, r, w);
    tick();
    drive(4'hC, 1'b0, 32'h0000_00F0, 32'h0000_000F, 1'b0, 4'h6);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || result !== 32'hF000_1200 || out_rd !== 4'h5) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b %h rd=%h want 1 f0001200 5", i, out_valid, result, out_rd); end
      tick();
    end
    out_ready = 1'b1;
    model(4'hC, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0, m_flags, r, w);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h0000_00FF || out_rd !== 4'h6) begin errors++; $display("FAIL no_bubble: got v=%b %h rd=%h want 1 000000ff 6", out_valid, result, out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    drive(4'h2, 1'b1, 32'd3, 32'd10, 1'b0, 4'h7);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_valid: got %b want 0", out_valid); end
    checks++; if (flags !== m_flags) begin errors++; $display("FAIL flush_flags: got %b want %b", flags, m_flags); end
    out_ready = 1'b0;
    drive(4'hD, 1'b0, 32'h0, 32'h1234, 1'b0, 4'h8);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held_valid: got %b want 0", out_valid); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] r, a, b; logic w, v, s, sc; logic [3:0] op, rd;
    for (int i = 0; i < 80; i++) begin
      v = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15)); s = 1'($urandom); sc = 1'($urandom);
      a = pick_operand(); b = pick_operand(); rd = 4'($urandom);
      drive(op, s, a, b, sc, rd);
      in_valid = v;
`ifndef ALU_MUL_EN
      mul_en = 1'($urandom);
`endif
      r = '0; w = 1'b0;
      if (v) model(op, a, b, sc, s, m_flags, r, w);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== v) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, v); end
      if (v) begin
        checks++; if (result !== r || out_wr_en !== w || out_rd !== rd) begin errors++; $display("FAIL rand_result[%0d] op=%h: got %h wr=%b rd=%h want %h wr=%b rd=%h", i, op, result, out_wr_en, out_rd, r, w, rd); end
      end
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL rand_flags[%0d] op=%h s=%b: got %b want %b", i, op, s, flags, m_flags); end
    end
    in_valid = 1'b0;
    mul_en = 1'b0;
    tick();
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    logic [3:0] f0;
    f0 = m_flags;
    drive(4'hD, 1'b1, 32'h0001_0000, 32'h0001_0001, 1'b0, 4'h9);
    mul_en = 1'b1;
    tick();
    drive(4'h4, 1'b0, 32'h1, 32'h1, 1'b0, 4'h1);
    for (int i = 1; i <= 32; i++) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy[%0d]: got rdy=%b v=%b want 0/0", i, in_ready, out_valid); end
      tick();
    end
    in_valid = 1'b0;
    m_flags = {1'b0, 1'b0, f0[1:0]};
    checks++; if (out_valid !== 1'b1 || result !== 32'h0001_0000 || out_wr_en !== 1'b1) begin errors++; $display("FAIL mul_result: got v=%b %h wr=%b want 1 00010000 1", out_valid, result, out_wr_en); end
    checks++; if (flags !== m_flags) begin errors++; $display("FAIL mul_flags: got %b want %b", flags, m_flags); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add_overflow();
    test_cmp_adc();
    test_mov_flags();
    test_back_to_back();
    test_flush();
`ifdef ALU_MUL_EN
    test_mul();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
